// File: rtl/fp_id_btn_debounce_if.sv
// fp_id_btn_debounce_if: front-panel ID button/LED bundle (raw button and LED clear in; debounced level, press strobe and LED out)
interface fp_id_btn_debounce_if;
  logic iFP_ID_BTN_N;
  logic iID_LED_CLR;
  logic oFP_ID_BTN_N;
  logic oPressPulse;
  logic oFP_ID_LED_N;
  modport master (output iFP_ID_BTN_N, iID_LED_CLR, input oFP_ID_BTN_N, oPressPulse, oFP_ID_LED_N);
  modport slave (input iFP_ID_BTN_N, iID_LED_CLR, output oFP_ID_BTN_N, oPressPulse, oFP_ID_LED_N);
endinterface

// File: rtl/fp_id_btn_debounce.sv
// fp_id_btn_debounce: synchronizes and debounces the active-low ID button, emits a press strobe and toggles the ID LED (ports: iClk, iRst_n async active-low, bus slave)
module fp_id_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input logic iClk,
  input logic iRst_n,
  fp_id_btn_debounce_if.slave bus
);
  typedef enum logic [1:0] {RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sync1_q, sync2_q;
  logic btn_q, btn_d, pulse_q, pulse_d, led_q, led_d;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RELEASED;
      cnt_q <= '0;
      btn_q <= 1'b1;
      pulse_q <= 1'b0;
      led_q <= 1'b1;
    end else begin
      sync1_q <= bus.iFP_ID_BTN_N;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      btn_q <= btn_d;
      pulse_q <= pulse_d;
      led_q <= led_d;
    end
  // cnt stays 0 outside the debounce states and is cleared on every state change
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    unique case (state_q)
      RELEASED: state_d = sync2_q ? RELEASED : DEB_PRESS;
      DEB_PRESS: begin
        state_d = sync2_q ? RELEASED : (cnt_q == LAST ? PRESSED : DEB_PRESS);
        cnt_d = (!sync2_q && cnt_q != LAST) ? cnt_q + CNT_W'(1) : '0;
      end
      PRESSED: state_d = sync2_q ? DEB_RELEASE : PRESSED;
      DEB_RELEASE: begin
        state_d = !sync2_q ? PRESSED : (cnt_q == LAST ? RELEASED : DEB_RELEASE);
        cnt_d = (sync2_q && cnt_q != LAST) ? cnt_q + CNT_W'(1) : '0;
      end
      default: state_d = RELEASED;
    endcase
  end
  // outputs are registered from the next state so they change on the acceptance edge
  always_comb begin
    pulse_d = state_q == DEB_PRESS && state_d == PRESSED;
    btn_d = !(state_d == PRESSED || state_d == DEB_RELEASE);
    led_d = bus.iID_LED_CLR ? 1'b1 : (pulse_d ? ~led_q : led_q);
  end
  assign bus.oFP_ID_BTN_N = btn_q;
  assign bus.oPressPulse = pulse_q;
  assign bus.oFP_ID_LED_N = led_q;
endmodule

// File: tb/tb_fp_id_btn_debounce.sv
// tb_fp_id_btn_debounce: directed checks of debounce timing, press strobe, LED toggle/clear and reset abort
module tb_fp_id_btn_debounce;
  logic iClk, iRst_n;
  int n_tests = 0, n_fail = 0;
  fp_id_btn_debounce_if bus();
  fp_id_btn_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;
  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask
  task automatic accept(input logic lvl, input logic led0, input logic led1, input logic clr_last);
    bus.iFP_ID_BTN_N = lvl;
    for (int e = 1; e <= 7; e++) begin
      if (e == 7) bus.iID_LED_CLR = clr_last;
      tick();
      bus.iID_LED_CLR = 1'b0;
      chk("acc_btn", bus.oFP_ID_BTN_N, e == 7 ? lvl : ~lvl);
      chk("acc_pulse", bus.oPressPulse, e == 7 && !lvl);
      chk("acc_led", bus.oFP_ID_LED_N, e == 7 ? led1 : led0);
    end
  endtask
  initial begin
    iRst_n = 1'b0;
    bus.iFP_ID_BTN_N = 1'b1;
    bus.iID_LED_CLR = 1'b0;
    tick();
    tick();
    chk("rst_btn", bus.oFP_ID_BTN_N, 1'b1);
    chk("rst_pulse", bus.oPressPulse, 1'b0);
    chk("rst_led", bus.oFP_ID_LED_N, 1'b1);
    iRst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_btn", bus.oFP_ID_BTN_N, 1'b1);
    end
    accept(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_pulse", bus.oPressPulse, 1'b0);
      chk("hold_btn", bus.oFP_ID_BTN_N, 1'b0);
    end
    accept(1'b1, 1'b0, 1'b0, 1'b0);
    bus.iFP_ID_BTN_N = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.iFP_ID_BTN_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_btn", bus.oFP_ID_BTN_N, 1'b1);
      chk("glitch_pulse", bus.oPressPulse, 1'b0);
      chk("glitch_led", bus.oFP_ID_LED_N, 1'b0);
    end
    accept(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.iFP_ID_BTN_N = i == 2 ? 1'b0 : 1'b1;
      tick();
      chk("bounce_btn", bus.oFP_ID_BTN_N, 1'b0);
      chk("bounce_pulse", bus.oPressPulse, 1'b0);
    end
    bus.iFP_ID_BTN_N = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("rel_btn", bus.oFP_ID_BTN_N, e == 7);
      chk("rel_pulse", bus.oPressPulse, 1'b0);
      chk("rel_led", bus.oFP_ID_LED_N, 1'b1);
    end
    accept(1'b0, 1'b1, 1'b1, 1'b1);
    accept(1'b1, 1'b1, 1'b1, 1'b0);
    accept(1'b0, 1'b1, 1'b0, 1'b0);
    accept(1'b1, 1'b0, 1'b0, 1'b0);
    bus.iFP_ID_BTN_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pre_rst_btn", bus.oFP_ID_BTN_N, 1'b1);
    end
    iRst_n = 1'b0;
    #1;
    chk("abort_btn", bus.oFP_ID_BTN_N, 1'b1);
    chk("abort_pulse", bus.oPressPulse, 1'b0);
    chk("abort_led", bus.oFP_ID_LED_N, 1'b1);
    tick();
    iRst_n = 1'b1;
    accept(1'b0, 1'b1, 1'b0, 1'b0);
    bus.iID_LED_CLR = 1'b1;
    tick();
    bus.iID_LED_CLR = 1'b0;
    chk("clr_led", bus.oFP_ID_LED_N, 1'b1);
    chk("clr_pulse", bus.oPressPulse, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
